// File: rtl/data_mem_responder.sv
// Purpose: MEM-stage data responder, word RAM with byte strobes, one response per request.
// Latency: response pulse in the cycle after edge E+LAT (acceptance at edge E); throughput 1 per LAT+2 cycles.
// Backpressure: req_ready_o is high only in IDLE; request inputs are ignored while busy.
module data_mem_responder #(
    parameter int DEPTH = 128,
    parameter int LAT   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,
    output logic        req_ready_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      cnt_q;
    logic            lat_write_q;
    logic [AW-1:0]   lat_idx_q;
    logic [31:0]     lat_wdata_q;
    logic [3:0]      lat_wstrb_q;
    logic            lat_err_q;
    logic            accept;
    logic            req_err;
    logic            wait_done;

    logic [31:0]     mem [DEPTH];

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i && (state_q == IDLE);
    assign wait_done   = (state_q == WAIT) && (cnt_q == 4'd0);

    // Full-width word index compare so high addresses never alias onto low words.
    assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:2] >= 30'(DEPTH));

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wait counter and latched copy of the accepted request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q       <= 4'd0;
            lat_write_q <= 1'b0;
            lat_idx_q   <= '0;
            lat_wdata_q <= 32'd0;
            lat_wstrb_q <= 4'd0;
            lat_err_q   <= 1'b0;
        end else if (accept) begin
            cnt_q       <= LAT_M1;
            lat_write_q <= req_write_i;
            lat_idx_q   <= req_addr_i[AW+1:2];
            lat_wdata_q <= req_wdata_i;
            lat_wstrb_q <= req_wstrb_i;
            lat_err_q   <= req_err;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Response registers: loaded on the edge entering RESP, cleared on every other edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
        end else if (wait_done) begin
            resp_valid_o <= 1'b1;
            resp_err_o   <= lat_err_q;
            resp_rdata_o <= (lat_err_q || lat_write_q) ? 32'd0 : mem[lat_idx_q];
        end else begin
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
        end
    end

    // Store commit on the edge leaving RESP; a reset before that edge drops the store whole.
    always_ff @(posedge clk_i) begin
        if (rst_i && (state_q == RESP) && lat_write_q && !lat_err_q) begin
            for (int k = 0; k < 4; k++) begin
                if (lat_wstrb_q[k]) begin
                    mem[lat_idx_q][8*k +: 8] <= lat_wdata_q[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: directed self-checking bench for data_mem_responder (LAT=2 and LAT=1 instances).
// Latency: expects the response pulse LAT+1 sampled cycles after acceptance.
// Backpressure: checks ready stays low from acceptance through the response cycle.
module tb_data_mem_responder;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_write, a_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_addr, a_wdata, a_resp_rdata;
    logic [3:0]  a_wstrb;

    logic        b_valid, b_write, b_ready, b_resp_valid, b_resp_err;
    logic [31:0] b_addr, b_wdata, b_resp_rdata;
    logic [3:0]  b_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    data_mem_responder #(.DEPTH(128), .LAT(2)) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (a_valid),
        .req_write_i  (a_write),
        .req_addr_i   (a_addr),
        .req_wdata_i  (a_wdata),
        .req_wstrb_i  (a_wstrb),
        .req_ready_o  (a_ready),
        .resp_valid_o (a_resp_valid),
        .resp_rdata_o (a_resp_rdata),
        .resp_err_o   (a_resp_err)
    );

    data_mem_responder #(.DEPTH(128), .LAT(1)) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .req_valid_i  (b_valid),
        .req_write_i  (b_write),
        .req_addr_i   (b_addr),
        .req_wdata_i  (b_wdata),
        .req_wstrb_i  (b_wstrb),
        .req_ready_o  (b_ready),
        .resp_valid_o (b_resp_valid),
        .resp_rdata_o (b_resp_rdata),
        .resp_err_o   (b_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One request on instance A; returns data/err, cycles to pulse and ready-low cycles seen.
    task automatic a_req(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output logic e,
                         output int lat, output int rdy_low);
        @(negedge clk);
        check("ready_before_req", {31'd0, a_ready}, 32'd1);
        a_valid = 1'b1; a_write = w; a_addr = addr; a_wdata = wd; a_wstrb = st;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 32'hFFFF_FFFC; a_wdata = 32'h0; a_wstrb = 4'h0;
        lat = 0; rdy_low = 0; rd = 32'h0; e = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (!a_ready) rdy_low++;
            if (a_resp_valid) begin
                rd = a_resp_rdata;
                e  = a_resp_err;
                break;
            end
        end
        @(negedge clk);
        check("pulse_width", {31'd0, a_resp_valid}, 32'd0);
        check("ready_after", {31'd0, a_ready}, 32'd1);
        check("idle_rdata", a_resp_rdata, 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat, rdy_low, pulses;
    logic [31:0] seen_rd;
    int          pos [3];

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_wstrb = 0;
        b_valid = 0; b_write = 0; b_addr = 0; b_wdata = 0; b_wstrb = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, a_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        check("rst_rdata", a_resp_rdata, 32'd0);
        check("rst_err", {31'd0, a_resp_err}, 32'd0);
        rst_n = 1'b1;

        // 1: full store then load
        a_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, e, lat, rdy_low);
        check("t1_st_lat", lat, 32'd3);
        check("t1_st_rdylow", rdy_low, 32'd3);
        check("t1_st_err", {31'd0, e}, 32'd0);
        check("t1_st_rdata", rd, 32'd0);
        a_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t1_ld_data", rd, 32'hDEADBEEF);
        check("t1_ld_lat", lat, 32'd3);

        // 2: partial-lane stores
        a_req(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, e, lat, rdy_low);
        a_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t2_lane0", rd, 32'hDEADBEAA);
        a_req(1'b1, 32'h10, 32'h12340000, 4'b1100, rd, e, lat, rdy_low);
        a_req(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t2_lane23", rd, 32'h1234BEAA);

        // 3: error cases and no aliasing
        a_req(1'b0, 32'h13, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t3_mis_err", {31'd0, e}, 32'd1);
        check("t3_mis_rdata", rd, 32'd0);
        a_req(1'b0, 32'h200, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t3_oor_err", {31'd0, e}, 32'd1);
        check("t3_oor_rdata", rd, 32'd0);
        a_req(1'b1, 32'h0, 32'h0BADF00D, 4'b1111, rd, e, lat, rdy_low);
        a_req(1'b1, 32'h200, 32'hFFFFFFFF, 4'b1111, rd, e, lat, rdy_low);
        check("t3_oor_st_err", {31'd0, e}, 32'd1);
        a_req(1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t3_no_alias", rd, 32'h0BADF00D);
        a_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, e, lat, rdy_low);
        check("t3_nostrb_err", {31'd0, e}, 32'd0);

        // 4: inputs held/changed while busy
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b0; a_addr = 32'h10;
        @(posedge clk);
        pulses = 0; seen_rd = 32'h0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("t4_busy_ready", {31'd0, a_ready}, 32'd0);
            if (a_resp_valid) begin
                pulses++;
                seen_rd = a_resp_rdata;
            end
            a_addr = 32'h10 + 32'(4 * i);
            a_write = i[0];
        end
        @(negedge clk);
        if (a_resp_valid) pulses++;
        check("t4_ready_idle", {31'd0, a_ready}, 32'd1);
        a_valid = 1'b0; a_write = 1'b0;
        check("t4_pulses", pulses, 32'd1);
        check("t4_data", seen_rd, 32'h1234BEAA);
        a_req(1'b0, 32'h14, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t4_no_store", {31'd0, e}, 32'd0);

        // 5: reset during WAIT abandons the store
        a_req(1'b1, 32'h20, 32'h11111111, 4'b1111, rd, e, lat, rdy_low);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 32'h20; a_wdata = 32'h55555555; a_wstrb = 4'hF;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, a_resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_resp_valid) pulses++;
        end
        check("t5_no_pulse", pulses, 32'd0);
        check("t5_ready", {31'd0, a_ready}, 32'd1);
        a_req(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, rdy_low);
        check("t5_data_kept", rd, 32'h11111111);

        // 6: LAT=1 instance, valid held high: store then back-to-back loads
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 32'h0; b_wdata = 32'hCAFEF00D; b_wstrb = 4'hF;
        @(posedge clk);
        #1;
        b_write = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (b_resp_valid) begin
                if (pulses < 3) pos[pulses] = i;
                if (pulses == 1) seen_rd = b_resp_rdata;
                pulses++;
            end
        end
        b_valid = 1'b0;
        check("t6_pulses", pulses, 32'd3);
        check("t6_pos0", pos[0], 32'd2);
        check("t6_pos1", pos[1], 32'd5);
        check("t6_pos2", pos[2], 32'd8);
        check("t6_data", seen_rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
